pll_cfg_loader: RTL

Parametrised serial configuration engine for fractional-N PLL/ramp synthesizers: shifts a programmable set of N-bit registers, highest index first and MSB first, over a 3-wire LE/CLK/DATA interface with configurable bit rate and latch timing. It replaces the fixed-sequence power-on loader. It adds software-triggered reprogramming, per-register update masks, frame snapshotting, a busy/done handshake and a synchronised lock-detect input. It sits between the radar control logic and the synthesizer pins, on the 40 MHz reference clock domain.

---
 rtl/pll_cfg_loader_pkg.sv | 17 +
 rtl/spi_word_tx.sv | 73 +++++++
 rtl/pll_cfg_loader.sv | 106 ++++++++++
 3 files changed

// File: rtl/pll_cfg_loader_pkg.sv
// pll_cfg_loader_pkg: fmcw synthesizer defaults and mask-scan helper shared by the loader.
package pll_cfg_loader_pkg;
    localparam int REF_CLK_HZ    = 40_000_000;
    localparam int SCLK_HZ       = 20_000_000;
    localparam int DEF_NUM_REGS  = 10;
    localparam int DEF_REG_WIDTH = 32;
    localparam int DEF_CLK_DIV   = REF_CLK_HZ / (2 * SCLK_HZ);
    localparam logic [DEF_NUM_REGS*DEF_REG_WIDTH-1:0] DEF_REGS = {
        32'h0000_0007, 32'h0040_1006, 32'h00C0_0005, 32'h0180_4004, 32'h0030_0003,
        32'h0000_8012, 32'h0640_0011, 32'h2000_0010, 32'h0000_0000, 32'h0038_0000
    };
    function automatic int hi_below(logic [31:0] m, int lim);
        hi_below = -1;
        for (int i = 0; i < 32; i++)
            if (i < lim && m[i]) hi_below = i;
    endfunction
endpackage

// File: rtl/spi_word_tx.sv
// spi_word_tx: shifts one word MSB first on LE/CLK/DATA, then holds LE high for the latch time.
module spi_word_tx #(
    parameter int REG_WIDTH = 32,
    parameter int CLK_DIV   = 1,
    parameter int LE_HIGH   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic [REG_WIDTH-1:0] word_i,
    output logic                 done_o,
    output logic                 le_o,
    output logic                 clk_o,
    output logic                 data_o
);
    localparam int BW = REG_WIDTH > 1 ? $clog2(REG_WIDTH) : 1;
    localparam int HW = $clog2(CLK_DIV + 1);
    localparam int LW = $clog2(LE_HIGH + 1);
    typedef enum logic [1:0] {W_IDLE, W_LOW, W_HIGH, W_LATCH} state_e;
    state_e               state_q, state_d;
    logic [REG_WIDTH-1:0] word_q, word_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [HW-1:0]        hp_q, hp_d;
    logic [LW-1:0]        lc_q, lc_d;
    logic                 le_q, le_d, clk_q, clk_d, data_q, data_d, hp_last, load;

    always_comb begin
        hp_last = hp_q == HW'(CLK_DIV - 1);
        done_o  = state_q == W_LATCH && lc_q == LW'(LE_HIGH - 1);
        load    = start_i && (state_q == W_IDLE || done_o);
        state_d = state_q;
        word_d  = load ? word_i : word_q;
        bit_d   = load ? BW'(REG_WIDTH - 1) : bit_q;
        if (load) state_d = W_LOW;
        else if (done_o) state_d = W_IDLE;
        else if (state_q == W_LOW && hp_last) state_d = W_HIGH;
        else if (state_q == W_HIGH && hp_last) begin
            state_d = bit_q == '0 ? W_LATCH : W_LOW;
            bit_d   = bit_q == '0 ? bit_q : bit_q - 1'b1;
        end
        hp_d   = state_d == state_q && (state_q == W_LOW || state_q == W_HIGH) ? hp_q + 1'b1 : '0;
        lc_d   = state_d == W_LATCH && state_q == W_LATCH ? lc_q + 1'b1 : '0;
        le_d   = !(state_d inside {W_LOW, W_HIGH});
        clk_d  = state_d == W_HIGH;
        data_d = state_d inside {W_LOW, W_HIGH} ? word_d[bit_d] : 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= W_IDLE;
            word_q  <= '0;
            bit_q   <= '0;
            hp_q    <= '0;
            lc_q    <= '0;
            le_q    <= 1'b1;
            clk_q   <= 1'b0;
            data_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            bit_q   <= bit_d;
            hp_q    <= hp_d;
            lc_q    <= lc_d;
            le_q    <= le_d;
            clk_q   <= clk_d;
            data_q  <= data_d;
        end
    end

    assign le_o   = le_q;
    assign clk_o  = clk_q;
    assign data_o = data_q;
endmodule

// File: rtl/pll_cfg_loader.sv
// pll_cfg_loader: snapshots masked PLL registers and streams them highest index first over 3-wire SPI.
module pll_cfg_loader
    import pll_cfg_loader_pkg::*;
#(
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int REG_WIDTH  = DEF_REG_WIDTH,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int LE_HIGH    = 2,
    parameter bit AUTO_START = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [NUM_REGS*REG_WIDTH-1:0] regs_i,
    input  logic [NUM_REGS-1:0]           mask_i,
    input  logic                          start_i,
    input  logic                          pwr_en_i,
    input  logic                          muxout_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          lock_o,
    output logic                          ce_o,
    output logic                          le_o,
    output logic                          clk_o,
    output logic                          data_o
);
    localparam int RW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_e;
    state_e                        state_q, state_d;
    logic [NUM_REGS*REG_WIDTH-1:0] shadow_q, shadow_d;
    logic [NUM_REGS-1:0]           mask_q, mask_d;
    logic [RW-1:0]                 idx_q, idx_d;
    logic                          auto_q, auto_d, busy_q, busy_d, done_q, done_d;
    logic                          ce_q, sync_q, lock_q, word_start, word_done;
    logic [REG_WIDTH-1:0]          word;
    logic [31:0]                   scan;
    int                            nxt;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        mask_d   = mask_q;
        auto_d   = auto_q;
        scan     = '0;
        nxt      = -1;
        if (state_q == S_IDLE && (start_i || auto_q)) begin
            shadow_d = regs_i;
            mask_d   = auto_q ? '1 : mask_i;
            auto_d   = 1'b0;
            scan[NUM_REGS-1:0] = mask_d;
            nxt      = hi_below(scan, 32);
            state_d  = nxt < 0 ? S_DONE : S_SEND;
        end else if (state_q == S_SEND && word_done) begin
            scan[NUM_REGS-1:0] = mask_q;
            nxt      = hi_below(scan, int'(idx_q));
            state_d  = nxt < 0 ? S_DONE : S_SEND;
        end else if (state_q == S_DONE) state_d = S_IDLE;
        word_start = nxt >= 0;
        idx_d      = nxt >= 0 ? RW'(nxt) : idx_q;
        // The word is taken from next-state values so the first bit leaves on the acceptance edge.
        word       = shadow_d[int'(idx_d)*REG_WIDTH +: REG_WIDTH];
        busy_d     = state_d != S_IDLE;
        done_d     = state_d == S_DONE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            shadow_q <= '0;
            mask_q   <= '0;
            idx_q    <= '0;
            auto_q   <= AUTO_START;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ce_q     <= 1'b0;
            sync_q   <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            mask_q   <= mask_d;
            idx_q    <= idx_d;
            auto_q   <= auto_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ce_q     <= pwr_en_i;
            sync_q   <= muxout_i;
            lock_q   <= sync_q;
        end
    end

    spi_word_tx #(.REG_WIDTH(REG_WIDTH), .CLK_DIV(CLK_DIV), .LE_HIGH(LE_HIGH)) u_tx (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .start_i (word_start),
        .word_i  (word),
        .done_o  (word_done),
        .le_o    (le_o),
        .clk_o   (clk_o),
        .data_o  (data_o)
    );

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign ce_o   = ce_q;
    assign lock_o = lock_q;
endmodule
